// File: rtl/fir_filter_if.sv
// Sample stream bundle for fir_filter: one signed input sample and one signed
// filtered result per clock, no handshake.
interface fir_filter_if;
   logic signed [7:0]  Xin;
   logic signed [15:0] y;

   modport master (
      output Xin,
      input  y
   );

   modport slave (
      input  Xin,
      output y
   );
endinterface

// File: rtl/fir_filter.sv
// Transposed-form fixed-coefficient FIR, 8-bit signed in, saturated 16-bit signed out.
// Define FIR_CSHM_EN to build tap products from a shared odd-multiple alphabet instead of '*'.
module fir_filter #(
   parameter int                  N_TAPS = 4,
   parameter logic [8*N_TAPS-1:0] COEFFS = {8'sd1, 8'sd5, -8'sd2, 8'sd3},
   parameter int                  ACC_W  = 16 + $clog2(N_TAPS)
) (
   input  logic         clk,
   input  logic         rst_n,
   fir_filter_if.slave  bus
);

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

   function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
      if (v > SAT_MAX) begin
         return 16'sh7fff;
      end else if (v < SAT_MIN) begin
         return 16'sh8000;
      end else begin
         return v[15:0];
      end
   endfunction

   // Index into the odd-multiple alphabet {1,3,...,15} for a nibble value v != 0.
   function automatic int odd_idx(input int v);
      int t;
      t = v;
      if (t == 0) return 0;
      while ((t % 2) == 0) t = t / 2;
      return (t - 1) / 2;
   endfunction

   // Left shift that turns the odd alphabet entry back into nibble value v.
   function automatic int odd_shift(input int v);
      int t;
      int s;
      t = v;
      s = 0;
      if (t == 0) return 0;
      while ((t % 2) == 0) begin
         t = t / 2;
         s = s + 1;
      end
      return s;
   endfunction

   logic signed [ACC_W-1:0] prod_p0 [N_TAPS];
   logic signed [ACC_W-1:0] s       [1:N_TAPS-1];
   logic signed [15:0]      y_p1;

   // Stage 0: combinational tap products of the current sample
`ifdef FIR_CSHM_EN
   logic signed [15:0] xe;
   logic signed [15:0] alpha [8];

   assign xe       = 16'(bus.Xin);
   assign alpha[0] = xe;
   assign alpha[1] = (xe <<< 1) + xe;
   assign alpha[2] = (xe <<< 2) + xe;
   assign alpha[3] = (xe <<< 3) - xe;
   assign alpha[4] = (xe <<< 3) + xe;
   assign alpha[5] = (xe <<< 3) + (xe <<< 1) + xe;
   assign alpha[6] = (xe <<< 3) + (xe <<< 2) + xe;
   assign alpha[7] = (xe <<< 4) - xe;

   for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
      localparam logic signed [7:0] C_K   = COEFFS[8*k +: 8];
      localparam int                CV    = int'(C_K);
      localparam int                MAG   = (CV < 0) ? -CV : CV;
      localparam int                LO    = MAG % 16;
      localparam int                HI    = MAG / 16;
      localparam int                IDX_L = odd_idx(LO);
      localparam int                SH_L  = odd_shift(LO);
      localparam int                IDX_H = odd_idx(HI);
      localparam int                SH_H  = odd_shift(HI);

      logic signed [15:0] sel_lo;
      logic signed [15:0] sel_hi;
      logic signed [15:0] mag;

      if (LO == 0) begin : g_lo_zero
         assign sel_lo = '0;
      end else begin : g_lo_sel
         assign sel_lo = alpha[IDX_L] <<< SH_L;
      end

      if (HI == 0) begin : g_hi_zero
         assign sel_hi = '0;
      end else begin : g_hi_sel
         assign sel_hi = alpha[IDX_H] <<< SH_H;
      end

      // |c|*Xin never exceeds 128*128, so the 16-bit sum and its negation are exact
      assign mag = (sel_hi <<< 4) + sel_lo;

      if (CV < 0) begin : g_neg
         assign prod_p0[k] = ACC_W'(-mag);
      end else begin : g_pos
         assign prod_p0[k] = ACC_W'(mag);
      end
   end
`else
   for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
      localparam logic signed [7:0] C_K = COEFFS[8*k +: 8];

      logic signed [15:0] mult;

      assign mult       = 16'(C_K) * 16'(bus.Xin);
      assign prod_p0[k] = ACC_W'(mult);
   end
`endif

   // Stage 1: transposed delay line and saturated output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 1; k < N_TAPS; k++) begin
            s[k] <= '0;
         end
         y_p1 <= '0;
      end else begin
         s[N_TAPS-1] <= prod_p0[N_TAPS-1];
         for (int k = 1; k < N_TAPS - 1; k++) begin
            s[k] <= prod_p0[k] + s[k+1];
         end
         y_p1 <= sat16(prod_p0[0] + s[1]);
      end
   end

   assign bus.y = y_p1;

endmodule

// File: tb/tb_fir_filter.sv
// Bench for fir_filter: a default-coefficient instance and an all -128 instance
// are driven in lockstep and compared against a sample-history reference model.
module tb_fir_filter;

   localparam int NT = 4;

   logic clk;
   logic rst_n;

   fir_filter_if bus_a ();
   fir_filter_if bus_b ();

   fir_filter #(
      .N_TAPS (NT)
   ) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.slave)
   );

   fir_filter #(
      .N_TAPS (NT),
      .COEFFS ({-8'sd128, -8'sd128, -8'sd128, -8'sd128})
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vec_cnt  = 0;
   int fail_cnt = 0;

   int coef_a [NT] = '{3, -2, 5, 1};
   int coef_b [NT] = '{-128, -128, -128, -128};
   int hist   [NT];

   task automatic check(input string tag, input int got, input int exp);
      vec_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int model_a();
      int acc = 0;
      for (int k = 0; k < NT; k++) acc += coef_a[k] * hist[k];
      return sat(acc);
   endfunction

   function automatic int model_b();
      int acc = 0;
      for (int k = 0; k < NT; k++) acc += coef_b[k] * hist[k];
      return sat(acc);
   endfunction

   // Present x, take one rising edge, then check both outputs 1 time unit later.
   task automatic step(input int x, input string tag);
      bus_a.Xin = 8'(x);
      bus_b.Xin = 8'(x);
      @(posedge clk);
      for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = x;
      #1;
      check({tag, "_a"}, int'(bus_a.y), model_a());
      check({tag, "_b"}, int'(bus_b.y), model_b());
   endtask

   // Pulse reset between edges; outputs must clear without waiting for a clock.
   task automatic pulse_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check({tag, "_rst_a"}, int'(bus_a.y), 0);
      check({tag, "_rst_b"}, int'(bus_b.y), 0);
      for (int k = 0; k < NT; k++) hist[k] = 0;
      #1;
      rst_n = 1'b1;
   endtask

   task automatic run_table_a(input string tag, input int xs[$], input int ys[$]);
      for (int i = 0; i < xs.size(); i++) begin
         step(xs[i], tag);
         check($sformatf("%s_tbl%0d", tag, i), int'(bus_a.y), ys[i]);
      end
   endtask

   task automatic run_table_b(input string tag, input int xs[$], input int ys[$]);
      for (int i = 0; i < xs.size(); i++) begin
         step(xs[i], tag);
         check($sformatf("%s_tbl%0d", tag, i), int'(bus_b.y), ys[i]);
      end
   endtask

   initial begin
      for (int k = 0; k < NT; k++) hist[k] = 0;
      rst_n     = 1'b0;
      bus_a.Xin = 'x;
      bus_b.Xin = 'x;
      repeat (3) @(posedge clk);
      #1;
      check("reset_a", int'(bus_a.y), 0);
      check("reset_b", int'(bus_b.y), 0);
      #2;
      rst_n = 1'b1;

      run_table_a("impulse", '{1, 0, 0, 0, 0}, '{3, -2, 5, 1, 0});

      pulse_reset("step");
      run_table_a("step", '{1, 1, 1, 1, 1, 1}, '{3, 1, 6, 7, 7, 7});

      pulse_reset("seq");
      run_table_a("seq", '{-3, 1, 0, -2, -1, 4, -5, 6, 0},
                  '{-9, 9, -17, -4, 2, 4, -30, 47, -33});

      pulse_reset("mid");
      run_table_a("mid_pre", '{-3, 1, 0, -2}, '{-9, 9, -17, -4});
      pulse_reset("mid");
      run_table_a("mid_post", '{1, 0, 0, 0, 0}, '{3, -2, 5, 1, 0});

      pulse_reset("satn");
      run_table_b("satn", '{-128, -128, -128, -128}, '{16384, 32767, 32767, 32767});

      pulse_reset("satp");
      run_table_b("satp", '{127, 127, 127, 127}, '{-16256, -32512, -32768, -32768});

      pulse_reset("ext");
      run_table_a("ext", '{-128, 0, 0, 0, 0}, '{-384, 256, -640, -128, 0});

      pulse_reset("rnd");
      for (int i = 0; i < 300; i++) begin
         int x;
         case ($urandom_range(0, 7))
            0:       x = -128;
            1:       x = 127;
            default: x = int'($urandom_range(0, 255)) - 128;
         endcase
         step(x, "rnd");
         if ($urandom_range(0, 49) == 0) pulse_reset("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

endmodule
